// File: rtl/apb_reg_slv.sv
// APB3 slave front-end for a bank of read/write register cells.
// It decodes each transfer into a one-hot write-enable pulse with write data,
// and returns read data selected from the flattened cell outputs.
// Every transfer completes with exactly one wait state. Bad accesses raise pslverr.
module apb_reg_slv #(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 12,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                       clk_reg,
  input  logic                       rst_reg_n,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic [DATA_W-1:0]          pwdata,
  output logic                       pready,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pslverr,
  output logic [NUM_REGS-1:0]        reg_wen,
  output logic [DATA_W-1:0]          reg_wdata,
  input  logic [NUM_REGS*DATA_W-1:0] reg_rdata
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_prdata;
  logic                r_pslverr;
  logic [NUM_REGS-1:0] r_reg_wen;
  logic [DATA_W-1:0]   r_reg_wdata;

  // The word index is zero-extended by one bit so that NUM_REGS == 2**(ADDR_W-2)
  // still fits in the comparison width.
  logic [ADDR_W-2:0]   w_idx;
  logic                w_aligned;
  logic                w_in_range;
  logic                w_ro;
  logic [NUM_REGS-1:0] w_onehot;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_hit;
  logic                w_err;
  logic                w_wr_ok;
  logic                w_start;

  assign w_idx     = {1'b0, paddr[ADDR_W-1:2]};
  assign w_aligned = (paddr[1:0] == 2'b00);

  // Address decode. The loop matches the index only against existing
  // registers, so out-of-range addresses never index past the mask or the read bus.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_in_range  = 1'b0;
    w_ro        = 1'b0;
    w_onehot    = '0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == (ADDR_W-1)'(i)) begin
        w_in_range  = 1'b1;
        w_ro        = RO_MASK[i];
        w_onehot[i] = 1'b1;
        w_sel_rdata = reg_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_hit   = w_aligned & w_in_range;
  assign w_err   = ~w_hit | (pwrite & w_ro);
  assign w_wr_ok = w_hit & pwrite & ~w_ro;
  assign w_start = psel & penable;

  // Two-state transfer FSM; all bus and cell outputs are registered here.
  always_ff @(posedge clk_reg or negedge rst_reg_n) begin
    if (!rst_reg_n) begin
      r_state     <= ST_IDLE;
      r_prdata    <= '0;
      r_pslverr   <= 1'b0;
      r_reg_wen   <= '0;
      r_reg_wdata <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state     <= ST_RESP;
            r_reg_wen   <= w_wr_ok ? w_onehot : '0;
            r_reg_wdata <= pwdata;
            r_pslverr   <= w_err;
            r_prdata    <= (w_hit & ~pwrite) ? w_sel_rdata : '0;
          end
        end
        ST_RESP: begin
          // Leave after one cycle regardless of psel/penable. The write pulse
          // ends here, and prdata/reg_wdata hold their values.
          r_state   <= ST_IDLE;
          r_reg_wen <= '0;
          r_pslverr <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pready    = (r_state == ST_RESP);
  assign prdata    = r_prdata;
  assign pslverr   = r_pslverr;
  assign reg_wen   = r_reg_wen;
  assign reg_wdata = r_reg_wdata;

endmodule

// File: tb/tb_apb_reg_slv.sv
// Bench for apb_reg_slv: a table of directed transfers, random transfers against
// a register-bank reference model, and a reset-during-response sequence.
// The bench models the register cells. They have their own reset, so the
// front-end reset does not clear them.
module tb_apb_reg_slv;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 12;
  localparam int          NUM_REGS = 16;
  localparam logic [15:0] RO_TB    = 16'h0002;

  logic                       clk_reg;
  logic                       rst_reg_n;
  logic                       cell_rst_n;
  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [ADDR_W-1:0]          paddr;
  logic [DATA_W-1:0]          pwdata;
  logic                       pready;
  logic [DATA_W-1:0]          prdata;
  logic                       pslverr;
  logic [NUM_REGS-1:0]        reg_wen;
  logic [DATA_W-1:0]          reg_wdata;
  logic [NUM_REGS*DATA_W-1:0] reg_rdata;

  int n_checks = 0;
  int n_errors = 0;

  apb_reg_slv #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS),
    .RO_MASK (RO_TB)
  ) dut (
    .clk_reg  (clk_reg),
    .rst_reg_n(rst_reg_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .reg_wen  (reg_wen),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata)
  );

  initial clk_reg = 1'b0;
  always #5 clk_reg = ~clk_reg;

  // Register cells: each one captures reg_wdata on a clock edge where its enable is high.
  logic [DATA_W-1:0] cells [NUM_REGS];
  always_ff @(posedge clk_reg or negedge cell_rst_n) begin
    if (!cell_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cells[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) if (reg_wen[i]) cells[i] <= reg_wdata;
    end
  end

  // Flatten the cell outputs onto the read bus.
  always_comb begin
    reg_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_rdata[i*DATA_W +: DATA_W] = cells[i];
  end

  // Reference model: the expected contents of the register bank.
  logic [DATA_W-1:0] model [NUM_REGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Predict the response of one transfer from the decode rules.
  task automatic predict(input bit wr, input logic [ADDR_W-1:0] addr,
                         output logic err, output logic [15:0] wen,
                         output logic [DATA_W-1:0] rd);
    int unsigned idx;
    bit          hit;
    bit          ro;
    idx = int'(addr) / 4;
    hit = (int'(addr) % 4 == 0) && (idx < NUM_REGS);
    ro  = 1'b0;
    if (hit) ro = RO_TB[idx];
    err = !hit || (wr && ro);
    wen = (wr && !err) ? 16'(1 << idx) : 16'h0;
    rd  = (!wr && hit) ? model[idx] : '0;
  endtask

  task automatic commit(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    logic              err;
    logic [15:0]       wen;
    logic [DATA_W-1:0] rd;
    predict(wr, addr, err, wen, rd);
    if (wr && !err) model[int'(addr) / 4] = wdata;
  endtask

  // One complete APB transfer. Drives and samples happen on the falling edge.
  task automatic xfer(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                      input logic exp_err, input logic [15:0] exp_wen,
                      input logic [DATA_W-1:0] exp_rd, input string tag);
    int waits;
    @(negedge clk_reg);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk_reg);
    penable = 1'b1;
    check({tag, " access1_pready"}, 64'(pready), 64'd0);
    check({tag, " access1_wen"}, 64'(reg_wen), 64'd0);
    waits = 0;
    while (!pready && waits < 8) begin
      @(negedge clk_reg);
      waits++;
    end
    check({tag, " wait_states"}, 64'(waits), 64'd1);
    if (pready) begin
      check({tag, " pslverr"}, 64'(pslverr), 64'(exp_err));
      check({tag, " reg_wen"}, 64'(reg_wen), 64'(exp_wen));
      if (wr) check({tag, " reg_wdata"}, 64'(reg_wdata), 64'(wdata));
      else    check({tag, " prdata"}, 64'(prdata), 64'(exp_rd));
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk_reg);
    check({tag, " after_resp"}, {62'd0, pready, pslverr}, 64'd0);
    check({tag, " after_wen"}, 64'(reg_wen), 64'd0);
  endtask

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              exp_err;
    logic [15:0]       exp_wen;
    logic [DATA_W-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin : main
    logic              err;
    logic [15:0]       wen;
    logic [DATA_W-1:0] rd;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                w;

    vecs[0] = '{1'b1, 12'h00C, 32'hA5A5_0001, 1'b0, 16'h0008, 32'h0};
    vecs[1] = '{1'b0, 12'h00C, 32'h0,         1'b0, 16'h0000, 32'hA5A5_0001};
    vecs[2] = '{1'b1, 12'h040, 32'h1234_5678, 1'b1, 16'h0000, 32'h0};
    vecs[3] = '{1'b0, 12'h040, 32'h0,         1'b1, 16'h0000, 32'h0};
    vecs[4] = '{1'b1, 12'h006, 32'h8765_4321, 1'b1, 16'h0000, 32'h0};
    vecs[5] = '{1'b0, 12'h006, 32'h0,         1'b1, 16'h0000, 32'h0};
    vecs[6] = '{1'b1, 12'h004, 32'hFFFF_FFFF, 1'b1, 16'h0000, 32'h0};
    vecs[7] = '{1'b0, 12'h004, 32'h0,         1'b0, 16'h0000, 32'h0};

    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst_reg_n = 1'b0; cell_rst_n = 1'b0;
    repeat (2) @(negedge clk_reg);
    check("reset_pready", 64'(pready), 64'd0);
    check("reset_pslverr", 64'(pslverr), 64'd0);
    check("reset_wen", 64'(reg_wen), 64'd0);
    check("reset_prdata", 64'(prdata), 64'd0);
    check("reset_wdata", 64'(reg_wdata), 64'd0);
    rst_reg_n = 1'b1; cell_rst_n = 1'b1;

    // Directed table: basic write/read, out-of-range, misaligned, read-only.
    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err,
           vecs[i].exp_wen, vecs[i].exp_rd, $sformatf("vec%0d", i));
      commit(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    end

    // Fill every register, then read all of them back.
    for (int i = 0; i < NUM_REGS; i++) begin
      a = 12'(4 * i);
      d = 32'(i) * 32'h1111_1111;
      predict(1'b1, a, err, wen, rd);
      xfer(1'b1, a, d, err, wen, rd, $sformatf("fill_w%0d", i));
      commit(1'b1, a, d);
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      a = 12'(4 * i);
      predict(1'b0, a, err, wen, rd);
      xfer(1'b0, a, 32'h0, err, wen, rd, $sformatf("fill_r%0d", i));
    end

    // Reset pulled in the response cycle of a write to register 2.
    @(negedge clk_reg);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'hDEAD_BEEF;
    @(negedge clk_reg);
    penable = 1'b1;
    @(negedge clk_reg);
    check("rstmid_pready_before", 64'(pready), 64'd1);
    check("rstmid_wen_before", 64'(reg_wen), 64'h0004);
    #1 rst_reg_n = 1'b0;
    #1;
    check("rstmid_outputs", {61'd0, pready, pslverr, |reg_wen}, 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk_reg);
    rst_reg_n = 1'b1;
    predict(1'b0, 12'h008, err, wen, rd);
    check("rstmid_model_kept", 64'(rd), 64'h2222_2222);
    xfer(1'b0, 12'h008, 32'h0, err, wen, rd, "rstmid_readback");

    // Random transfers, mostly in range, with some misaligned or out-of-range addresses.
    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 12'($urandom_range(0, 16'h4F));
      d = $urandom;
      predict(w, a, err, wen, rd);
      xfer(w, a, d, err, wen, rd, $sformatf("rnd%0d", n));
      commit(w, a, d);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
